// File: rtl/usart_pkg.sv
// Shared definitions for the USART receive path: parity modes, RX FSM states and FIFO entry sizing.
package usart_pkg;

  localparam logic [1:0] PARITY_NONE     = 2'd0;
  localparam logic [1:0] PARITY_EVEN     = 2'd1;
  localparam logic [1:0] PARITY_ODD      = 2'd2;
  localparam logic [1:0] PARITY_NONE_ALT = 2'd3;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // FIFO entry is {frame_err, parity_err, data}; the struct itself lives next to DATA_BITS.
  function automatic int unsigned entry_width(input int unsigned data_bits);
    return data_bits + 2;
  endfunction

endpackage

// File: rtl/usart_rx_fifo_if.sv
// Show-ahead receive byte stream between the USART receiver and the system-side consumer.
interface usart_rx_fifo_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 frame_error;
  logic                 parity_error;
  logic                 valid;
  logic                 ready;

  modport master (output data_out, frame_error, parity_error, valid, input ready);
  modport slave  (input data_out, frame_error, parity_error, valid, output ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a push while full only lands when a pop frees a slot that cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       serial_clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (level == '0);
  assign full     = (level == LVL_W'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge serial_clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; stale words are never exposed while empty.
  always_ff @(posedge serial_clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/usart_rx_fifo.sv
// Oversampling UART receiver feeding a show-ahead FIFO with RTS flow control.
// Define USART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module usart_rx_fifo
  import usart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_WIDTH  = 12
) (
  input  logic                          serial_clock,
  input  logic                          reset,
  input  logic [DIV_WIDTH-1:0]          clocks_per_bit,
  input  logic [1:0]                    parity_mode,
  input  logic                          rx_pin,
  usart_rx_fifo_if.master               rx_bus,
  output logic                          overrun,
  input  logic                          overrun_clear,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          rts_pin
);
  localparam int unsigned OS_LOG2 = $clog2(OVERSAMPLE);
  localparam int unsigned TICK_W  = OS_LOG2;
  localparam int unsigned MID     = OVERSAMPLE / 2 - 1;
  localparam int unsigned BIT_W   = $clog2(DATA_BITS + 1);
  localparam int unsigned ENTRY_W = entry_width(DATA_BITS);
  localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic                 frame_err;
    logic                 parity_err;
    logic [DATA_BITS-1:0] data;
  } rx_entry_t;

  logic [1:0]           rx_sync_q;
  logic                 rx_s;
  logic [DIV_WIDTH-1:0] divisor_c, reload_c, div_cnt_q;
  logic [TICK_W-1:0]    tick_cnt_q;
  logic                 tick_c, sample_c, bit_val_c, restart_c, parity_on_c;
  rx_state_t            state_q, state_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 push_c, frame_err_c, pop_c, full_c, empty_c;
  rx_entry_t            entry_in_c, head_c;

  // Two-flop synchroniser for the asynchronous RX line.
  always_ff @(posedge serial_clock) begin
    if (reset) rx_sync_q <= 2'b11;
    else       rx_sync_q <= {rx_sync_q[0], rx_pin};
  end
  assign rx_s = rx_sync_q[1];

  // Oversample tick generator; a zero divisor degenerates to a tick every cycle.
  assign divisor_c = clocks_per_bit >> OS_LOG2;
  assign reload_c  = (divisor_c == '0) ? '0 : divisor_c - DIV_WIDTH'(1);
  assign tick_c    = (div_cnt_q == '0) && !restart_c;

  always_ff @(posedge serial_clock) begin
    if (reset) begin
      div_cnt_q  <= '0;
      tick_cnt_q <= '0;
    end else if (restart_c) begin
      div_cnt_q  <= reload_c;
      tick_cnt_q <= '0;
    end else begin
      div_cnt_q <= (div_cnt_q == '0) ? reload_c : div_cnt_q - DIV_WIDTH'(1);
      if (tick_c) tick_cnt_q <= tick_cnt_q + TICK_W'(1);
    end
  end

`ifdef USART_RX_MAJORITY_EN
  localparam int unsigned SAMPLE_AT = MID + 1;
  logic [1:0] hist_q;

  // hist_q holds the samples from the two previous ticks (mid-1, mid) when deciding at mid+1.
  always_ff @(posedge serial_clock) begin
    if (reset)       hist_q <= 2'b11;
    else if (tick_c) hist_q <= {hist_q[0], rx_s};
  end
  assign bit_val_c = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  localparam int unsigned SAMPLE_AT = MID;
  assign bit_val_c = rx_s;
`endif

  assign sample_c    = tick_c && (tick_cnt_q == TICK_W'(SAMPLE_AT));
  assign parity_on_c = !((parity_mode == PARITY_NONE) || (parity_mode == PARITY_NONE_ALT));

  always_ff @(posedge serial_clock) begin
    if (reset) begin
      state_q   <= RX_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_err_d   = par_err_q;
    restart_c   = 1'b0;
    push_c      = 1'b0;
    frame_err_c = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d   = RX_START;
          restart_c = 1'b1;
          bit_cnt_d = '0;
          par_err_d = 1'b0;
        end
      end
      RX_START: begin
        if (sample_c) state_d = bit_val_c ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (sample_c) begin
          shift_d   = {bit_val_c, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) state_d = parity_on_c ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (sample_c) begin
          par_err_d = (^shift_q) ^ bit_val_c ^ (parity_mode == PARITY_ODD);
          state_d   = RX_STOP;
        end
      end
      RX_STOP: begin
        if (sample_c) begin
          push_c      = 1'b1;
          frame_err_c = !bit_val_c;
          state_d     = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign entry_in_c.frame_err  = frame_err_c;
  assign entry_in_c.parity_err = par_err_q;
  assign entry_in_c.data       = shift_q;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .serial_clock (serial_clock),
    .reset        (reset),
    .push         (push_c),
    .push_data    (entry_in_c),
    .pop          (pop_c),
    .pop_data     (head_c),
    .full         (full_c),
    .empty        (empty_c),
    .level        (fifo_level)
  );

  assign pop_c               = rx_bus.valid && rx_bus.ready;
  assign rx_bus.valid        = !empty_c;
  assign rx_bus.data_out     = empty_c ? '0   : head_c.data;
  assign rx_bus.frame_error  = empty_c ? 1'b0 : head_c.frame_err;
  assign rx_bus.parity_error = empty_c ? 1'b0 : head_c.parity_err;

  // Sticky overrun: a fresh drop wins over a same-cycle clear.
  always_ff @(posedge serial_clock) begin
    if (reset)                            overrun <= 1'b0;
    else if (push_c && full_c && !pop_c)  overrun <= 1'b1;
    else if (overrun_clear)               overrun <= 1'b0;
  end

  always_ff @(posedge serial_clock) begin
    if (reset) rts_pin <= 1'b1;
    else       rts_pin <= (fifo_level >= LEVEL_W'(FIFO_DEPTH - 2));
  end

endmodule

// File: tb/tb_usart_rx_fifo.sv
// Directed + randomized bench for usart_rx_fifo; a frame-level model predicts each received entry.
module tb_usart_rx_fifo;
  import usart_pkg::*;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned DIV_WIDTH  = 12;
  localparam int unsigned BIT_CYC    = 64;

  logic                 serial_clock = 1'b0;
  logic                 reset        = 1'b1;
  logic [DIV_WIDTH-1:0] clocks_per_bit = DIV_WIDTH'(BIT_CYC);
  logic [1:0]           parity_mode  = PARITY_NONE;
  logic                 rx_pin       = 1'b1;
  logic                 overrun;
  logic                 overrun_clear = 1'b0;
  logic [4:0]           fifo_level;
  logic                 rts_pin;

  int          checks = 0;
  int          errors = 0;
  int unsigned cycle  = 0;
  int unsigned pop_cycle = 0;
  logic [9:0]  got_q[$];
  logic [9:0]  exp_q[$];

  usart_rx_fifo_if #(.DATA_BITS(DATA_BITS)) rx_bus ();

  usart_rx_fifo #(
    .DATA_BITS  (DATA_BITS),
    .OVERSAMPLE (OVERSAMPLE),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_WIDTH  (DIV_WIDTH)
  ) dut (
    .serial_clock   (serial_clock),
    .reset          (reset),
    .clocks_per_bit (clocks_per_bit),
    .parity_mode    (parity_mode),
    .rx_pin         (rx_pin),
    .rx_bus         (rx_bus),
    .overrun        (overrun),
    .overrun_clear  (overrun_clear),
    .fifo_level     (fifo_level),
    .rts_pin        (rts_pin)
  );

  always #5 serial_clock = ~serial_clock;
  always @(posedge serial_clock) cycle <= cycle + 1;

  // Consumer side: every accepted word is logged as {frame_err, parity_err, data}.
  always @(negedge serial_clock) begin
    if (!reset && rx_bus.valid && rx_bus.ready) begin
      got_q.push_back({rx_bus.frame_error, rx_bus.parity_error, rx_bus.data_out});
      pop_cycle = cycle;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge serial_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected entry from the line-level description of a frame.
  function automatic logic [9:0] model(input logic [7:0] d, input logic [1:0] mode,
                                       input logic pbit, input logic stop);
    logic perr;
    perr = 1'b0;
    if (mode == 2'd1) perr = ((^d) ^ pbit) == 1'b1;
    if (mode == 2'd2) perr = ((^d) ^ pbit) == 1'b0;
    return {~stop, perr, d};
  endfunction

  task automatic drive_bit(input logic v, input bit glitch);
    rx_pin = v;
    if (glitch) begin
      step(BIT_CYC / 2);
      rx_pin = ~v;
      step(1);
      rx_pin = v;
      step(BIT_CYC / 2 - 1);
    end else begin
      step(BIT_CYC);
    end
  endtask

  // Full frame on the line followed by two idle bit times; a 0 stop bit is held well past its centre.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] mode, input logic pbit,
                            input logic stop, input int glitch_bit);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], glitch_bit == i);
    if (mode == 2'd1 || mode == 2'd2) drive_bit(pbit, 1'b0);
    if (stop) begin
      drive_bit(1'b1, 1'b0);
    end else begin
      rx_pin = 1'b0;
      step(48);
      rx_pin = 1'b1;
      step(16);
    end
    step(2 * BIT_CYC);
  endtask

  task automatic expect_one(input string tag, input logic [9:0] exp);
    check({tag, "_count"}, 32'(got_q.size()), 32'd1);
    if (got_q.size() != 0) check(tag, 32'(got_q[0]), 32'(exp));
    got_q.delete();
  endtask

  initial begin
    logic [7:0]  d;
    logic [1:0]  m;
    logic        p, s;
    int unsigned edge_cycle, lat;
    bit          ovr_model;

    rx_bus.ready = 1'b0;
    step(5);
    check("rst_valid", 32'(rx_bus.valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_rts", 32'(rts_pin), 32'd1);
    check("rst_data", 32'(rx_bus.data_out), 32'd0);
    check("rst_flags", 32'({rx_bus.frame_error, rx_bus.parity_error}), 32'd0);
    reset = 1'b0;
    step(5);
    check("rts_after_rst", 32'(rts_pin), 32'd0);

    // Basic frame and end-to-end latency.
    rx_bus.ready = 1'b1;
    edge_cycle = cycle;
    send_frame(8'hA5, 2'd0, 1'b0, 1'b1, -1);
    lat = pop_cycle - edge_cycle;
    check("latency_window", 32'(lat >= 600 && lat <= 620), 32'd1);
    expect_one("a5", 10'h0A5);

    // Parity: 0x07 has odd weight, so even mode wants parity bit 1.
    parity_mode = 2'd1;
    send_frame(8'h07, 2'd1, 1'b0, 1'b1, -1);
    expect_one("even_p0", 10'h107);
    send_frame(8'h07, 2'd1, 1'b1, 1'b1, -1);
    expect_one("even_p1", 10'h007);
    parity_mode = 2'd2;
    send_frame(8'h07, 2'd2, 1'b0, 1'b1, -1);
    expect_one("odd_p0", 10'h007);
    send_frame(8'h07, 2'd2, 1'b1, 1'b1, -1);
    expect_one("odd_p1", 10'h107);

    // Framing error then a clean frame.
    parity_mode = 2'd0;
    send_frame(8'h3C, 2'd0, 1'b0, 1'b0, -1);
    expect_one("frame_err", 10'h23C);
    send_frame(8'h11, 2'd0, 1'b0, 1'b1, -1);
    expect_one("after_ferr", 10'h011);

    // Short low pulse must not start a frame.
    rx_pin = 1'b0;
    step(20);
    rx_pin = 1'b1;
    step(4 * BIT_CYC);
    check("glitch_nopush", 32'(got_q.size()), 32'd0);
    check("glitch_valid", 32'(rx_bus.valid), 32'd0);
    send_frame(8'hC3, 2'd0, 1'b0, 1'b1, -1);
    expect_one("after_glitch", 10'h0C3);

    // Randomized frames across all parity modes and stop-bit values.
    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom);
      m = 2'($urandom_range(0, 3));
      p = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 3) != 0);
      parity_mode = m;
      step(2);
      send_frame(d, m, p, s, -1);
      expect_one("rand", model(d, m, p, s));
    end

    // Fill past capacity with the consumer stalled.
    parity_mode  = 2'd0;
    rx_bus.ready = 1'b0;
    exp_q.delete();
    ovr_model = 1'b0;
    for (int n = 1; n <= FIFO_DEPTH + 2; n++) begin
      d = 8'($urandom);
      send_frame(d, 2'd0, 1'b0, 1'b1, -1);
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(model(d, 2'd0, 1'b0, 1'b1));
      else ovr_model = 1'b1;
      check("fill_level", 32'(fifo_level), 32'(exp_q.size()));
      check("fill_rts", 32'(rts_pin), 32'(exp_q.size() >= FIFO_DEPTH - 2));
      check("fill_overrun", 32'(overrun), 32'(ovr_model));
    end
    rx_bus.ready = 1'b1;
    step(FIFO_DEPTH + 4);
    rx_bus.ready = 1'b0;
    check("drain_count", 32'(got_q.size()), 32'(FIFO_DEPTH));
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (i < got_q.size()) check("drain_order", 32'(got_q[i]), 32'(exp_q[i]));
    end
    got_q.delete();
    check("drain_level", 32'(fifo_level), 32'd0);
    check("overrun_held", 32'(overrun), 32'd1);
    overrun_clear = 1'b1;
    step(1);
    overrun_clear = 1'b0;
    step(1);
    check("overrun_cleared", 32'(overrun), 32'd0);

    // Reset in the middle of a frame with one word already queued.
    send_frame(8'h33, 2'd0, 1'b0, 1'b1, -1);
    check("pre_rst_level", 32'(fifo_level), 32'd1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    reset = 1'b1;
    step(3);
    check("midrst_valid", 32'(rx_bus.valid), 32'd0);
    check("midrst_level", 32'(fifo_level), 32'd0);
    check("midrst_rts", 32'(rts_pin), 32'd1);
    rx_pin = 1'b1;
    reset  = 1'b0;
    step(3 * BIT_CYC);
    rx_bus.ready = 1'b1;
    send_frame(8'h5A, 2'd0, 1'b0, 1'b1, -1);
    expect_one("post_rst", 10'h05A);

`ifdef USART_RX_MAJORITY_EN
    send_frame(8'h5A, 2'd0, 1'b0, 1'b1, 2);
    expect_one("majority_glitch", 10'h05A);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
